// File: rtl/sprite_pkg.sv
//------------------------------------------------------------------------------
// Module   : sprite_pkg
// Brief    : Shared OAM entry layout, table size and evaluator state encoding.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package sprite_pkg;

    localparam int OAM_ENTRIES = 64;
    localparam int OAM_AW      = 6;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] attr;
        logic [7:0] tile;
        logic [7:0] y;
    } oam_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } eval_state_t;

    // Row of the target line inside a sprite; wraps modulo 256 so sprites
    // near the bottom of the Y range continue onto the top lines.
    function automatic logic [7:0] line_diff(input logic [7:0] line, input logic [7:0] y);
        return line - y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_line_buffer.sv
//------------------------------------------------------------------------------
// Module   : sprite_line_buffer
// Brief    : Secondary sprite register file, one write port, one combinational read.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_line_buffer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int DW    = 36
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; the owner gates validity by count.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/sprite_evaluator.sv
//------------------------------------------------------------------------------
// Module   : sprite_evaluator
// Brief    : Walks all 64 OAM entries per scanline and collects intersecting
//            sprites into a secondary buffer. SPRITE_ZERO_FLAG_EN adds the
//            sprite-zero-in-line flag.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sprite_evaluator
    import sprite_pkg::*;
#(
    parameter  int MAX_SPRITES   = 8,
    parameter  int SPRITE_HEIGHT = 8,
    localparam int IDXW          = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1,
    localparam int CNTW          = $clog2(MAX_SPRITES) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        scanline,
    output logic [OAM_AW-1:0] oam_read_addr,
    input  logic [31:0]       oam_read_data,
    output logic              busy,
    output logic              done,
    output logic [CNTW-1:0]   sprite_count,
    output logic              overflow,
    output logic              sprite0_in_line,
    input  logic [IDXW-1:0]   sec_read_idx,
    output logic [31:0]       sec_read_data,
    output logic [3:0]        sec_read_row
);

    localparam logic [CNTW-1:0]   c_CNT_MAX  = CNTW'(MAX_SPRITES);
    localparam logic [7:0]        c_HEIGHT   = 8'(SPRITE_HEIGHT);
    localparam logic [OAM_AW-1:0] c_LAST_IDX = OAM_AW'(OAM_ENTRIES - 1);

    eval_state_t       r_state;
    eval_state_t       w_state_nxt;
    logic [OAM_AW-1:0] r_idx;
    logic [7:0]        r_line;
    logic [CNTW-1:0]   r_count;
    logic              r_overflow;

    oam_entry_t        w_entry;
    logic [7:0]        w_diff;
    logic              w_hit;
    logic              w_full;
    logic              w_we;
    logic              w_ovf;
    logic              w_last;
    logic [35:0]       w_rdata;

    assign w_entry = oam_entry_t'(oam_read_data);
    assign w_diff  = line_diff(r_line, w_entry.y);
    assign w_hit   = (r_state == ST_SCAN) && (w_diff < c_HEIGHT);
    assign w_full  = (r_count == c_CNT_MAX);
    assign w_we    = w_hit && !w_full;
    assign w_ovf   = w_hit && w_full;
    assign w_last  = (r_idx == c_LAST_IDX);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        oam_read_addr = '0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                busy          = 1'b1;
                oam_read_addr = r_idx;
                if (w_ovf || w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_idx      <= '0;
            r_line     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (start) begin
                r_idx      <= '0;
                r_line     <= scanline;
                r_count    <= '0;
                r_overflow <= 1'b0;
            end
        end else if (r_state == ST_SCAN) begin
            if (w_we) begin
                r_count <= r_count + CNTW'(1);
            end
            if (w_ovf) begin
                r_overflow <= 1'b1;
            end
            if (!w_last && !w_ovf) begin
                r_idx <= r_idx + OAM_AW'(1);
            end
        end
    end

`ifdef SPRITE_ZERO_FLAG_EN
    logic r_sprite0;

    // Entry 0 can only ever land in slot 0, so its hit alone sets the flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sprite0 <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_sprite0 <= 1'b0;
        end else if (w_we && r_idx == '0) begin
            r_sprite0 <= 1'b1;
        end
    end

    assign sprite0_in_line = r_sprite0;
`else
    assign sprite0_in_line = 1'b0;
`endif

    sprite_line_buffer #(
        .DEPTH (MAX_SPRITES),
        .AW    (IDXW),
        .DW    (36)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_count[IDXW-1:0]),
        .i_wdata ({oam_read_data, w_diff[3:0]}),
        .i_raddr (sec_read_idx),
        .o_rdata (w_rdata)
    );

    assign sec_read_data = w_rdata[35:4];
    assign sec_read_row  = w_rdata[3:0];
    assign sprite_count  = r_count;
    assign overflow      = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sprite_evaluator.sv
//------------------------------------------------------------------------------
// Module   : tb_sprite_evaluator
// Brief    : Directed checks for sprite_evaluator at heights 8 and 16.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_sprite_evaluator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start8, start16;
    logic [7:0]  line8, line16;
    logic [5:0]  addr8, addr16;
    logic [31:0] rd8, rd16;
    logic        busy8, done8, ovf8, s08;
    logic        busy16, done16, ovf16, s016;
    logic [3:0]  cnt8, cnt16;
    logic [2:0]  idx8, idx16;
    logic [31:0] sd8, sd16;
    logic [3:0]  row8, row16;
    logic [31:0] oam8  [64];
    logic [31:0] oam16 [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign rd8  = oam8[addr8];
    assign rd16 = oam16[addr16];

    sprite_evaluator #(.MAX_SPRITES(8), .SPRITE_HEIGHT(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .scanline(line8),
        .oam_read_addr(addr8), .oam_read_data(rd8), .busy(busy8), .done(done8),
        .sprite_count(cnt8), .overflow(ovf8), .sprite0_in_line(s08),
        .sec_read_idx(idx8), .sec_read_data(sd8), .sec_read_row(row8)
    );

    sprite_evaluator #(.MAX_SPRITES(8), .SPRITE_HEIGHT(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .scanline(line16),
        .oam_read_addr(addr16), .oam_read_data(rd16), .busy(busy16), .done(done16),
        .sprite_count(cnt16), .overflow(ovf16), .sprite0_in_line(s016),
        .sec_read_idx(idx16), .sec_read_data(sd16), .sec_read_row(row16)
    );

    typedef struct {
        logic [7:0] y;
        logic [7:0] line;
        logic       hit;
        logic [3:0] row;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int i, input logic [7:0] y);
        return {8'(i * 3 + 1), 8'(8'h5A ^ 8'(i)), 8'(i), y};
    endfunction

    task automatic fill(input bit s16, input logic [7:0] y);
        for (int i = 0; i < 64; i++) begin
            if (s16) oam16[i] = mk(i, y);
            else     oam8[i]  = mk(i, y);
        end
    endtask

    // Returns n = cycle index (relative to the accepting edge) in which done is seen.
    task automatic run(input bit s16, input logic [7:0] l, input int pulse_at, output int n);
        @(negedge clk);
        if (s16) begin start16 = 1'b1; line16 = l; end
        else     begin start8  = 1'b1; line8  = l; end
        @(negedge clk);
        start8 = 1'b0; start16 = 1'b0;
        n = 1;
        chk("busy_first_cycle", s16 ? busy16 : busy8, 1);
        chk("addr_first_cycle", s16 ? addr16 : addr8, 0);
        while (!(s16 ? done16 : done8) && n < 200) begin
            if (n == pulse_at) begin
                if (s16) begin start16 = 1'b1; line16 = 8'h80; end
                else     begin start8  = 1'b1; line8  = 8'h80; end
            end else begin
                start8 = 1'b0; start16 = 1'b0;
            end
            @(negedge clk);
            n++;
            if (n == 40) chk("addr_mid_scan", s16 ? addr16 : addr8, 39);
        end
        start8 = 1'b0; start16 = 1'b0;
        if (!(s16 ? done16 : done8)) chk("done_timeout", 0, 1);
        else                         chk("busy_low_at_done", s16 ? busy16 : busy8, 0);
    endtask

    vec_t vecs [9];
    int   n;
    logic exp_s0;
    bit   seen_done;
    int   slots [3];

    initial begin
        vecs[0] = '{8'h05, 8'h08, 1'b1, 4'd3};
        vecs[1] = '{8'h05, 8'h0C, 1'b1, 4'd7};
        vecs[2] = '{8'h05, 8'h0D, 1'b0, 4'd0};
        vecs[3] = '{8'h05, 8'h04, 1'b0, 4'd0};
        vecs[4] = '{8'hFC, 8'h00, 1'b1, 4'd4};
        vecs[5] = '{8'hFC, 8'h03, 1'b1, 4'd7};
        vecs[6] = '{8'hFC, 8'h04, 1'b0, 4'd0};
        vecs[7] = '{8'hFC, 8'hFC, 1'b1, 4'd0};
        vecs[8] = '{8'h40, 8'h47, 1'b1, 4'd7};
        slots   = '{3, 20, 63};
`ifdef SPRITE_ZERO_FLAG_EN
        exp_s0 = 1'b1;
`else
        exp_s0 = 1'b0;
`endif

        reset = 1'b0; start8 = 1'b0; start16 = 1'b0;
        line8 = '0; line16 = '0; idx8 = '0; idx16 = '0;
        fill(0, 8'hFF);
        fill(1, 8'hFF);
        repeat (3) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_count", cnt8, 0);
        chk("rst_overflow", ovf8, 0);
        chk("rst_sprite0", s08, 0);
        chk("rst_addr", addr8, 0);
        chk("rst_busy16", busy16, 0);
        chk("rst_count16", cnt16, 0);
        reset = 1'b1;

        // All entries off-line: full 64-entry walk, empty result.
        run(0, 8'd10, -1, n);
        chk("t1_latency", n, 65);
        chk("t1_count", cnt8, 0);
        chk("t1_overflow", ovf8, 0);
        @(negedge clk);
        chk("t1_done_one_cycle", done8, 0);

        // Scattered hits including the last entry.
        fill(0, 8'hFF);
        foreach (slots[s]) oam8[slots[s]] = mk(slots[s], 8'h05);
        run(0, 8'd8, -1, n);
        chk("t2_latency", n, 65);
        chk("t2_count", cnt8, 3);
        for (int s = 0; s < 3; s++) begin
            idx8 = 3'(s);
            #1;
            chk("t2_slot_data", sd8, mk(slots[s], 8'h05));
            chk("t2_slot_row", row8, 3);
        end

        // Ninth hit triggers overflow and early exit.
        fill(0, 8'h80);
        for (int i = 0; i < 9; i++) oam8[i] = mk(i, 8'h00);
        run(0, 8'd0, -1, n);
        chk("t3_latency", n, 10);
        chk("t3_count", cnt8, 8);
        chk("t3_overflow", ovf8, 1);
        idx8 = 3'd7;
        #1;
        chk("t3_slot7", sd8, mk(7, 8'h00));

        // Sprite zero at its bottom row, then one line past it.
        fill(0, 8'h80);
        oam8[0] = mk(0, 8'd100);
        run(0, 8'd107, -1, n);
        chk("t4_count", cnt8, 1);
        chk("t4_overflow_cleared", ovf8, 0);
        idx8 = 3'd0;
        #1;
        chk("t4_slot0", sd8, mk(0, 8'd100));
        chk("t4_row", row8, 7);
        chk("t4_sprite0", s08, exp_s0);
        run(0, 8'd108, -1, n);
        chk("t4_miss_count", cnt8, 0);
        chk("t4_sprite0_cleared", s08, 0);

        // Single-entry table: hit/miss and row for entry 5 across boundaries.
        for (int v = 0; v < 9; v++) begin
            fill(0, 8'h80);
            oam8[5] = mk(5, vecs[v].y);
            run(0, vecs[v].line, -1, n);
            chk($sformatf("vec%0d_count", v), cnt8, vecs[v].hit ? 1 : 0);
            if (vecs[v].hit) begin
                idx8 = 3'd0;
                #1;
                chk($sformatf("vec%0d_data", v), sd8, mk(5, vecs[v].y));
                chk($sformatf("vec%0d_row", v), row8, vecs[v].row);
            end
        end

        // Height 16: wrapped hit at row 13, start pulse mid-scan ignored.
        fill(1, 8'h80);
        oam16[7] = mk(7, 8'hF8);
        run(1, 8'h05, 20, n);
        chk("t5_latency", n, 65);
        chk("t5_count", cnt16, 1);
        #1;
        chk("t5_data", sd16, mk(7, 8'hF8));
        chk("t5_row", row16, 13);
        run(1, 8'h07, -1, n);
        chk("t5_last_row", row16, 15);
        run(1, 8'h08, -1, n);
        chk("t5_past_count", cnt16, 0);

        // Reset in the middle of a scan.
        fill(0, 8'hFF);
        foreach (slots[s]) oam8[slots[s]] = mk(slots[s], 8'h05);
        @(negedge clk);
        start8 = 1'b1; line8 = 8'd8;
        @(negedge clk);
        start8 = 1'b0;
        n = 1;
        while (n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("t6_count_before_reset", cnt8, 2);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_busy", busy8, 0);
        chk("t6_count", cnt8, 0);
        chk("t6_addr", addr8, 0);
        seen_done = 1'b0;
        for (int c = 0; c < 60; c++) begin
            seen_done |= done8;
            @(negedge clk);
        end
        chk("t6_no_done", seen_done, 0);
        run(0, 8'd8, -1, n);
        chk("t6_fresh_latency", n, 65);
        chk("t6_fresh_count", cnt8, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
